fetch_prefetch: RTL and testbench

Parametrised successor to the single-cycle fetch stage of the RISC-V pipeline. It owns the fetch PC, issues pipelined requests to an instruction memory with a valid/ready handshake and variable response latency, and buffers returned instructions in a QDEPTH-entry prefetch queue. It drives the IF/ID register with stall, flush and valid support. Redirects from EX (PCSrc) discard queued and in-flight instructions.

---
 rtl/fetch_prefetch.sv | 185 ++++++++++++++++++
 tb/tb_fetch_prefetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Pipelined instruction fetch: owns the fetch PC, issues credit-limited requests to
// instruction memory, buffers responses in a small prefetch queue and drives IF/ID.
module fetch_prefetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               QDEPTH   = 2,
  parameter logic [XLEN-1:0]  NOP      = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ALUOut,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] fpc_reg,      fpc_next;
  logic [XLEN-1:0] rsp_pc_reg,   rsp_pc_next;
  logic [AW-1:0]   head_reg,     head_next;
  logic [AW-1:0]   tail_reg,     tail_next;
  logic [CW-1:0]   count_reg,    count_next;
  logic [CW-1:0]   outst_reg,    outst_next;
  logic [CW-1:0]   drop_reg,     drop_next;
  logic [XLEN-1:0] pcd_reg,      pcd_next;
  logic [XLEN-1:0] instrd_reg,   instrd_next;
  logic [XLEN-1:0] pcplus4d_reg, pcplus4d_next;
  logic            validd_reg,   validd_next;

  logic [XLEN-1:0] q_pc    [QDEPTH];
  logic [XLEN-1:0] q_instr [QDEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW:0]     credit_sum;
  logic            fire;
  logic            rsp_keep;
  logic            flush;
  logic            q_empty;
  logic            pop;
  logic            bypass;
  logic            push;

  assign redirect   = (PCSrc == 2'b01) || (PCSrc == 2'b10);
  assign target     = (PCSrc == 2'b01) ? (ALUOut & ~XLEN'(1)) : PCTarget;
  // Credits cover both queued and in-flight instructions, so pushes never overflow.
  assign credit_sum = {1'b0, outst_reg} + {1'b0, count_reg};

  assign imem_req_valid = !reset && (credit_sum < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fpc_reg;
  assign fire           = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_reg == '0) && !redirect;
  assign flush    = FlushD || redirect;
  assign q_empty  = (count_reg == '0);
  assign pop      = !flush && !StallD && !q_empty;
  assign bypass   = !flush && !StallD && q_empty && rsp_keep;
  assign push     = rsp_keep && !bypass;

  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
      logic [XLEN-1:0] pc_reg;
      logic [XLEN-1:0] instr_reg;

      always_ff @(posedge clk) begin
        if (push && (tail_reg == AW'(gi))) begin
          pc_reg    <= rsp_pc_reg;
          instr_reg <= imem_rsp_data;
        end
      end

      assign q_pc[gi]    = pc_reg;
      assign q_instr[gi] = instr_reg;
    end
  endgenerate

  always_comb begin
    fpc_next    = fpc_reg;
    rsp_pc_next = rsp_pc_reg;
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    outst_next  = outst_reg + CW'(fire) - CW'(imem_rsp_valid);
    drop_next   = drop_reg;

    if (redirect) begin
      fpc_next    = target;
      rsp_pc_next = target;
      head_next   = '0;
      tail_next   = '0;
      count_next  = '0;
      // Everything still in flight after this edge belongs to the old path.
      drop_next   = outst_next;
    end else begin
      if (fire)
        fpc_next = fpc_reg + XLEN'(4);
      if (rsp_keep)
        rsp_pc_next = rsp_pc_reg + XLEN'(4);
      if (imem_rsp_valid && (drop_reg != '0))
        drop_next = drop_reg - CW'(1);
      if (push)
        tail_next = tail_reg + AW'(1);
      if (pop)
        head_next = head_reg + AW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    pcd_next      = pcd_reg;
    instrd_next   = instrd_reg;
    pcplus4d_next = pcplus4d_reg;
    validd_next   = validd_reg;

    if (flush) begin
      pcd_next      = '0;
      instrd_next   = NOP;
      pcplus4d_next = '0;
      validd_next   = 1'b0;
    end else if (StallD) begin
      validd_next   = validd_reg;
    end else if (pop) begin
      pcd_next      = q_pc[head_reg];
      instrd_next   = q_instr[head_reg];
      pcplus4d_next = q_pc[head_reg] + XLEN'(4);
      validd_next   = 1'b1;
    end else if (bypass) begin
      pcd_next      = rsp_pc_reg;
      instrd_next   = imem_rsp_data;
      pcplus4d_next = rsp_pc_reg + XLEN'(4);
      validd_next   = 1'b1;
    end else begin
      // Bubble keeps the last PC so the pipeline sees a stable address.
      instrd_next   = NOP;
      validd_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_reg      <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      outst_reg    <= '0;
      drop_reg     <= '0;
      pcd_reg      <= '0;
      instrd_reg   <= NOP;
      pcplus4d_reg <= '0;
      validd_reg   <= 1'b0;
    end else begin
      fpc_reg      <= fpc_next;
      rsp_pc_reg   <= rsp_pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      outst_reg    <= outst_next;
      drop_reg     <= drop_next;
      pcd_reg      <= pcd_next;
      instrd_reg   <= instrd_next;
      pcplus4d_reg <= pcplus4d_next;
      validd_reg   <= validd_next;
    end
  end

  assign PCD      = pcd_reg;
  assign instrD   = instrd_reg;
  assign PCPlus4D = pcplus4d_reg;
  assign validD   = validd_reg;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order instruction memory model
// whose responses can be held back to create multiple requests in flight.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ALUOut = '0;
  logic [31:0] PCTarget = '0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] PCD;
  logic [31:0] instrD;
  logic [31:0] PCPlus4D;
  logic        validD;

  logic        rsp_hold = 1'b0;
  logic [31:0] mq[$];
  int          vecs = 0;
  int          errs = 0;

  fetch_prefetch dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .ALUOut(ALUOut), .PCTarget(PCTarget),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .PCD(PCD), .instrD(instrD),
    .PCPlus4D(PCPlus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Memory: accepted requests queue up; one response per cycle unless held.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back(imem_req_addr);
      imem_rsp_valid <= 1'b0;
      if (!rsp_hold && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; PCSrc = 2'b00; StallD = 1'b0; FlushD = 1'b0;
    imem_req_ready = 1'b1; rsp_hold = 1'b0; ALUOut = '0; PCTarget = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    vecs++; if (validD !== 1'b0) begin errs++; $display("FAIL reset_validD: got %b want 0", validD); end
    vecs++; if (instrD !== 32'h00000013) begin errs++; $display("FAIL reset_instrD: got %h want 00000013", instrD); end
    vecs++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h/%h want 0/0", PCD, PCPlus4D); end
    reset = 1'b0;
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errs++; $display("FAIL reset_first_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    vecs++; if (validD !== 1'b0 || imem_req_addr !== 32'h4) begin errs++; $display("FAIL edge1_state: got validD=%b addr=%h want 0/00000004", validD, imem_req_addr); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      @(negedge clk);
      vecs++; if (PCD !== exp_pc || validD !== 1'b1) begin errs++; $display("FAIL seq_pc[%0d]: got %h v=%b want %h v=1", k, PCD, validD, exp_pc); end
      vecs++; if (PCPlus4D !== exp_pc + 32'h4 || instrD !== mem_word(exp_pc)) begin errs++; $display("FAIL seq_data[%0d]: got %h/%h want %h/%h", k, PCPlus4D, instrD, exp_pc + 32'h4, mem_word(exp_pc)); end
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_after [3];
    exp_after = '{32'hC, 32'h10, 32'h14};
    do_reset();
    repeat (4) @(negedge clk);
    vecs++; if (PCD !== 32'h8) begin errs++; $display("FAIL stall_start_pc: got %h want 00000008", PCD); end
    StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++; if (PCD !== 32'h8 || validD !== 1'b1 || instrD !== mem_word(32'h8)) begin errs++; $display("FAIL stall_hold[%0d]: got %h v=%b want 00000008 v=1", k, PCD, validD); end
      vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL stall_req_valid[%0d]: got %b want 0", k, imem_req_valid); end
    end
    StallD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++; if (PCD !== exp_after[k] || validD !== 1'b1 || instrD !== mem_word(exp_after[k])) begin errs++; $display("FAIL stall_release[%0d]: got %h v=%b want %h v=1", k, PCD, validD, exp_after[k]); end
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect_branch();
    do_reset();
    rsp_hold = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL br_credit: got %b want 0", imem_req_valid); end
    PCSrc = 2'b10; PCTarget = 32'h40;
    @(negedge clk);
    PCSrc = 2'b00; rsp_hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++; if (validD !== 1'b0) begin errs++; $display("FAIL br_drop[%0d]: got validD=%b PCD=%h want validD=0", k, validD, PCD); end
      if (k == 1) begin
        vecs++; if (imem_req_addr !== 32'h40 || imem_req_valid !== 1'b1) begin errs++; $display("FAIL br_req_addr: got %b/%h want 1/00000040", imem_req_valid, imem_req_addr); end
      end
    end
    @(negedge clk);
    vecs++; if (PCD !== 32'h40 || validD !== 1'b1 || instrD !== mem_word(32'h40)) begin errs++; $display("FAIL br_target: got %h v=%b i=%h want 00000040 v=1 i=%h", PCD, validD, instrD, mem_word(32'h40)); end
    $display("test_redirect_branch done");
  endtask

  task automatic test_redirect_jalr();
    do_reset();
    repeat (2) @(negedge clk);
    PCSrc = 2'b01; ALUOut = 32'h101;
    @(negedge clk);
    vecs++; if (validD !== 1'b0 || PCD !== 32'h0) begin errs++; $display("FAIL jalr_flush: got v=%b PCD=%h want v=0 PCD=0", validD, PCD); end
    vecs++; if (imem_req_addr !== 32'h100) begin errs++; $display("FAIL jalr_req_addr: got %h want 00000100", imem_req_addr); end
    PCSrc = 2'b00;
    @(negedge clk);
    vecs++; if (validD !== 1'b0) begin errs++; $display("FAIL jalr_drop: got validD=%b want 0", validD); end
    @(negedge clk);
    vecs++; if (PCD !== 32'h100 || PCPlus4D !== 32'h104 || validD !== 1'b1 || instrD !== mem_word(32'h100)) begin errs++; $display("FAIL jalr_target: got %h/%h v=%b want 00000100/00000104 v=1", PCD, PCPlus4D, validD); end
    PCSrc = 2'b11; PCTarget = 32'h40;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      vecs++; if (PCD !== 32'h100 + 32'(4 * k) || validD !== 1'b1) begin errs++; $display("FAIL pcsrc11_seq[%0d]: got %h v=%b want %h v=1", k, PCD, validD, 32'h100 + 32'(4 * k)); end
    end
    PCSrc = 2'b00;
    $display("test_redirect_jalr done");
  endtask

  task automatic test_ready_flush();
    do_reset();
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    vecs++; if (PCD !== 32'h8 || validD !== 1'b1) begin errs++; $display("FAIL nready_last: got %h v=%b want 00000008 v=1", PCD, validD); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++; if (validD !== 1'b0 || PCD !== 32'h8 || instrD !== 32'h13) begin errs++; $display("FAIL nready_bubble[%0d]: got v=%b PCD=%h i=%h want v=0 PCD=00000008 i=00000013", k, validD, PCD, instrD); end
      vecs++; if (imem_req_addr !== 32'hC || imem_req_valid !== 1'b1) begin errs++; $display("FAIL nready_addr[%0d]: got %b/%h want 1/0000000c", k, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    vecs++; if (validD !== 1'b0) begin errs++; $display("FAIL ready_resume_gap: got validD=%b want 0", validD); end
    @(negedge clk);
    vecs++; if (PCD !== 32'hC || validD !== 1'b1) begin errs++; $display("FAIL ready_resume: got %h v=%b want 0000000c v=1", PCD, validD); end
    StallD = 1'b1; FlushD = 1'b1;
    @(negedge clk);
    vecs++; if (validD !== 1'b0 || instrD !== 32'h13 || PCD !== 32'h0) begin errs++; $display("FAIL flush_over_stall: got v=%b i=%h PCD=%h want v=0 i=00000013 PCD=0", validD, instrD, PCD); end
    StallD = 1'b0; FlushD = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vecs++; if (PCD !== 32'h10 + 32'(4 * k) || validD !== 1'b1 || instrD !== mem_word(32'h10 + 32'(4 * k))) begin errs++; $display("FAIL flush_after[%0d]: got %h v=%b want %h v=1", k, PCD, validD, 32'h10 + 32'(4 * k)); end
    end
    $display("test_ready_flush done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vecs++; if (validD !== 1'b0 || PCD !== 32'h0 || instrD !== 32'h13 || imem_req_valid !== 1'b0) begin errs++; $display("FAIL mid_reset: got v=%b PCD=%h i=%h rv=%b want 0/0/00000013/0", validD, PCD, instrD, imem_req_valid); end
    do_reset();
    vecs++; if (imem_req_addr !== 32'h0) begin errs++; $display("FAIL mid_reset_fpc: got %h want 00000000", imem_req_addr); end
    repeat (2) @(negedge clk);
    vecs++; if (PCD !== 32'h0 || validD !== 1'b1 || instrD !== mem_word(32'h0)) begin errs++; $display("FAIL mid_reset_restart: got %h v=%b want 00000000 v=1", PCD, validD); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_branch();
    test_redirect_jalr();
    test_ready_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
